// File: rtl/pi_sched_pkg.sv
// pi_sched_pkg: shared types and saturating arithmetic for the time-multiplexed
// PI scheduler.
//   state_t  : sequencing FSM states (IDLE, SUB, MUL, KI, SUM, WB)
//   SAT_MAX / SAT_MIN : symmetric 32-bit clamp limits (+/-0x7FFFFFFF)
//   sat_add  : 32 + 32 -> 32, clamped
//   sat_mul  : 32 x 25 (signed) -> 57-bit product, clamped to 32
package pi_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SUB,
      MUL,
      KI,
      SUM,
      WB
   } state_t;

   localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [31:0] SAT_MIN = 32'sh8000_0001;

   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
      logic signed [32:0] sum;
      sum = 33'(a) + 33'(b);
      if (sum > 33'sd2147483647)
         return SAT_MAX;
      else if (sum < -33'sd2147483647)
         return SAT_MIN;
      else
         return sum[31:0];
   endfunction

   function automatic logic signed [31:0] sat_mul(input logic signed [31:0] a,
                                                  input logic signed [24:0] b);
      logic signed [56:0] prod;
      prod = 57'(a) * 57'(b);
      if (prod > 57'sd2147483647)
         return SAT_MAX;
      else if (prod < -57'sd2147483647)
         return SAT_MIN;
      else
         return prod[31:0];
   endfunction

endpackage

// File: rtl/pi_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req   : pending request vector
//   ptr   : highest-priority index this round
//   en    : arbitration allowed this cycle
//   grant : one-hot winner (all zero when none)
//   idx   : encoded winner index
//   valid : a winner exists
module rr_arbiter #(
   parameter int NCH = 4,
   parameter int CW  = $clog2(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [CW-1:0]  ptr,
   input  logic           en,
   output logic [NCH-1:0] grant,
   output logic [CW-1:0]  idx,
   output logic           valid
);

   always_comb begin
      int unsigned cand;
      cand  = 0;
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      if (en) begin
         // Scan from ptr upwards, wrapping; first hit wins.
         for (int unsigned k = 0; k < NCH; k++) begin
            cand = (32'(ptr) + k) % NCH;
            if (!valid && req[CW'(cand)]) begin
               grant[CW'(cand)] = 1'b1;
               idx              = CW'(cand);
               valid            = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pi_scheduler.sv
// pi_scheduler: one saturating PI datapath shared round-robin across NCH loops.
//   clk, rst   : clock, synchronous active-high reset
//   i_req      : per-channel new-sample pulse (merged into pending bits)
//   i_aim      : packed signed setpoints, channel c at [16c+15:16c]
//   i_real     : packed signed feedback, same packing
//   i_kp, i_ki : packed unsigned 24-bit gains, latched at grant
//   i_clr      : per-channel clear of integrator and accumulator
//   o_grant    : one-hot pulse, channel accepted and operands latched
//   o_en       : result-valid pulse, five cycles after o_grant
//   o_ch       : channel of the current o_en
//   o_value    : accumulator[31:16] of that channel, held between pulses
//   o_drop     : request merged into an already pending bit
//   o_busy     : FSM not in IDLE
module pi_scheduler
   import pi_sched_pkg::*;
#(
   parameter  int NCH = 4,
   localparam int CW  = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       i_req,
   input  logic [NCH*16-1:0]    i_aim,
   input  logic [NCH*16-1:0]    i_real,
   input  logic [NCH*24-1:0]    i_kp,
   input  logic [NCH*24-1:0]    i_ki,
   input  logic [NCH-1:0]       i_clr,
   output logic [NCH-1:0]       o_grant,
   output logic                 o_en,
   output logic [CW-1:0]        o_ch,
   output logic signed [15:0]   o_value,
   output logic [NCH-1:0]       o_drop,
   output logic                 o_busy
);

   state_t               state;
   logic [NCH-1:0]       pending;
   logic [CW-1:0]        ptr;
   logic [CW-1:0]        ch;
   logic                 kill;

   logic signed [15:0]   aim_q, real_q;
   logic [23:0]          kp_q, ki_q;
   logic signed [31:0]   p_q, kpp_q, kip_q, s_q;
   logic signed [31:0]   integ [NCH];
   logic signed [31:0]   acc   [NCH];

   logic [NCH-1:0]       arb_grant;
   logic [CW-1:0]        arb_idx;
   logic                 arb_valid;

   logic signed [15:0]   aim_sel, real_sel;
   logic [23:0]          kp_sel, ki_sel;
   logic                 kill_now;
   logic signed [31:0]   integ_new, acc_new;

   // WB also arbitrates so the next job's grant overlaps the write-back,
   // giving one job every five cycles.
   rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
      .req   (pending),
      .ptr   (ptr),
      .en    ((state == IDLE) || (state == WB)),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   always_comb begin
      aim_sel  = '0;
      real_sel = '0;
      kp_sel   = '0;
      ki_sel   = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (arb_grant[c]) begin
            aim_sel  = i_aim[16*c +: 16];
            real_sel = i_real[16*c +: 16];
            kp_sel   = i_kp[24*c +: 24];
            ki_sel   = i_ki[24*c +: 24];
         end
      end
   end

   // A clear that hits the in-flight channel kills the rest of the job.
   assign kill_now  = kill | ((state != IDLE) & i_clr[ch]);
   assign integ_new = sat_add(integ[ch], p_q);
   assign acc_new   = sat_add(acc[ch], s_q);
   assign o_busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pending <= '0;
         ptr     <= '0;
         ch      <= '0;
         kill    <= 1'b0;
         aim_q   <= '0;
         real_q  <= '0;
         kp_q    <= '0;
         ki_q    <= '0;
         p_q     <= '0;
         kpp_q   <= '0;
         kip_q   <= '0;
         s_q     <= '0;
         o_grant <= '0;
         o_en    <= 1'b0;
         o_ch    <= '0;
         o_value <= '0;
         o_drop  <= '0;
         for (int unsigned c = 0; c < NCH; c++) begin
            integ[c] <= '0;
            acc[c]   <= '0;
         end
      end else begin
         o_grant <= '0;
         o_en    <= 1'b0;
         o_drop  <= i_req & pending & ~arb_grant;
         pending <= (pending & ~arb_grant) | i_req;
         kill    <= (state == WB) ? 1'b0 : kill_now;

         for (int unsigned c = 0; c < NCH; c++) begin
            if (i_clr[c]) begin
               integ[c] <= '0;
               acc[c]   <= '0;
            end else if (!kill_now && (ch == CW'(c))) begin
               if (state == MUL) integ[c] <= integ_new;
               if (state == WB)  acc[c]   <= acc_new;
            end
         end

         case (state)
            IDLE: state <= IDLE;
            SUB: begin
               p_q   <= 32'(aim_q) - 32'(real_q);
               state <= MUL;
            end
            MUL: begin
               kpp_q <= sat_mul(p_q, $signed({1'b0, kp_q}));
               state <= KI;
            end
            KI: begin
               // integ[ch] already holds this job's updated integrator here.
               kip_q <= sat_mul(integ[ch], $signed({1'b0, ki_q}));
               state <= SUM;
            end
            SUM: begin
               s_q   <= sat_add(kpp_q, kip_q);
               state <= WB;
            end
            WB: begin
               if (!kill_now) begin
                  o_en    <= 1'b1;
                  o_ch    <= ch;
                  o_value <= acc_new[31:16];
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (arb_valid) begin
            o_grant <= arb_grant;
            ch      <= arb_idx;
            ptr     <= (arb_idx == CW'(NCH - 1)) ? '0 : arb_idx + 1'b1;
            aim_q   <= aim_sel;
            real_q  <= real_sel;
            kp_q    <= kp_sel;
            ki_q    <= ki_sel;
            kill    <= 1'b0;
            state   <= SUB;
         end
      end
   end

endmodule

// File: tb/tb_pi_scheduler.sv
module tb_pi_scheduler;

   localparam int NCH = 4;
   localparam int CW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NCH-1:0]      i_req;
   logic [NCH*16-1:0]   i_aim;
   logic [NCH*16-1:0]   i_real;
   logic [NCH*24-1:0]   i_kp;
   logic [NCH*24-1:0]   i_ki;
   logic [NCH-1:0]      i_clr;
   logic [NCH-1:0]      o_grant;
   logic                o_en;
   logic [CW-1:0]       o_ch;
   logic signed [15:0]  o_value;
   logic [NCH-1:0]      o_drop;
   logic                o_busy;

   logic signed [15:0]  aim_a  [NCH];
   logic signed [15:0]  real_a [NCH];
   logic [23:0]         kp_a   [NCH];
   logic [23:0]         ki_a   [NCH];

   pi_scheduler #(.NCH(NCH)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .i_aim   (i_aim),
      .i_real  (i_real),
      .i_kp    (i_kp),
      .i_ki    (i_ki),
      .i_clr   (i_clr),
      .o_grant (o_grant),
      .o_en    (o_en),
      .o_ch    (o_ch),
      .o_value (o_value),
      .o_drop  (o_drop),
      .o_busy  (o_busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      i_aim  = '0;
      i_real = '0;
      i_kp   = '0;
      i_ki   = '0;
      for (int c = 0; c < NCH; c++) begin
         i_aim[16*c +: 16]  = aim_a[c];
         i_real[16*c +: 16] = real_a[c];
         i_kp[24*c +: 24]   = kp_a[c];
         i_ki[24*c +: 24]   = ki_a[c];
      end
   end

   typedef struct {
      logic [CW-1:0]      ch;
      logic signed [15:0] aim;
      logic signed [15:0] rl;
      logic [23:0]        kp;
      logic [23:0]        ki;
      logic               clr;
      logic signed [15:0] exp;
   } vec_t;

   vec_t tbl [10];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int base;
   int gcyc [NCH];
   int ecyc [8];
   int ech  [8];
   int evl  [8];
   int en_n;
   int gseq [8];
   int gn;
   int drops;
   int odrops;
   logic seen;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      i_req = '0;
      i_clr = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_grant(input logic [CW-1:0] ch, input string tag);
      logic got;
      got = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         i_req = '0;
         if (o_grant[ch]) begin
            got = 1'b1;
            break;
         end
      end
      check({tag, " grant"}, 32'(got), 1);
   endtask

   task automatic run_job(input logic [CW-1:0] ch, input logic signed [15:0] aim,
                          input logic signed [15:0] rl, input logic [23:0] kp,
                          input logic [23:0] ki, input logic signed [15:0] exp,
                          input string tag);
      logic early;
      aim_a[ch]  = aim;
      real_a[ch] = rl;
      kp_a[ch]   = kp;
      ki_a[ch]   = ki;
      i_req      = '0;
      i_req[ch]  = 1'b1;
      wait_grant(ch, tag);
      // operands are latched at grant; scribbling over them must not matter
      aim_a[ch] = 16'sd0;
      kp_a[ch]  = '0;
      ki_a[ch]  = '0;
      early = 1'b0;
      for (int k = 1; k < 5; k++) begin
         step();
         if (o_en) early = 1'b1;
      end
      step();
      check({tag, " en_early"}, 32'(early), 0);
      check({tag, " en"}, 32'(o_en), 1);
      check({tag, " ch"}, 32'(o_ch), 32'(ch));
      check({tag, " value"}, o_value, exp);
      step();
      check({tag, " en_pulse"}, 32'(o_en), 0);
      check({tag, " value_hold"}, o_value, exp);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      i_req = '0;
      i_clr = '0;
      for (int c = 0; c < NCH; c++) begin
         aim_a[c] = '0; real_a[c] = '0; kp_a[c] = '0; ki_a[c] = '0;
      end

      //        ch  aim       real      kp         ki        clr   expected
      tbl[0] = '{2'd0, 16'sd1000,  16'sd0,      24'd32768, 24'd2,     1'b0, 16'sd500};
      tbl[1] = '{2'd0, 16'sd1000,  16'sd0,      24'd32768, 24'd2,     1'b0, 16'sd1000};
      tbl[2] = '{2'd2, -16'sd200,  16'sd300,    24'd65536, 24'd0,     1'b0, -16'sd500};
      tbl[3] = '{2'd3, 16'sd32767, -16'sd32768, 24'hFFFFFF, 24'd0,    1'b0, 16'sd32767};
      tbl[4] = '{2'd3, 16'sd32767, -16'sd32768, 24'hFFFFFF, 24'd0,    1'b0, 16'sd32767};
      tbl[5] = '{2'd3, 16'sd32767, -16'sd32768, 24'hFFFFFF, 24'd0,    1'b0, 16'sd32767};
      tbl[6] = '{2'd3, -16'sd32768, 16'sd32767, 24'hFFFFFF, 24'd0,    1'b1, -16'sd32768};
      tbl[7] = '{2'd3, -16'sd32768, 16'sd32767, 24'hFFFFFF, 24'd0,    1'b0, -16'sd32768};
      tbl[8] = '{2'd1, 16'sd5,     16'sd5,      24'd100,   24'd100,   1'b0, 16'sd0};
      tbl[9] = '{2'd2, 16'sd0,     16'sd0,      24'd0,     24'd65536, 1'b0, -16'sd1000};

      step();
      step();
      check("reset grant", 32'(o_grant), 0);
      check("reset en", 32'(o_en), 0);
      check("reset ch", 32'(o_ch), 0);
      check("reset value", o_value, 0);
      check("reset drop", 32'(o_drop), 0);
      check("reset busy", 32'(o_busy), 0);
      rst = 1'b0;

      // ---------------- table of single jobs ----------------
      for (int r = 0; r < 10; r++) begin
         if (tbl[r].clr) begin
            i_clr = '0;
            i_clr[tbl[r].ch] = 1'b1;
            step();
            i_clr = '0;
         end
         run_job(tbl[r].ch, tbl[r].aim, tbl[r].rl, tbl[r].kp, tbl[r].ki,
                 tbl[r].exp, $sformatf("row%0d", r));
      end

      // ---------------- round robin ----------------
      do_reset();
      for (int c = 0; c < NCH; c++) begin
         aim_a[c] = 16'(c * 10); real_a[c] = '0; kp_a[c] = 24'd65536; ki_a[c] = '0;
         gcyc[c] = -1;
      end
      en_n = 0;
      i_req = '1;
      step();
      i_req = '0;
      base = cyc;
      for (int k = 0; k < 30; k++) begin
         step();
         for (int c = 0; c < NCH; c++)
            if (o_grant[c]) gcyc[c] = cyc;
         if (o_en && en_n < 8) begin
            ecyc[en_n] = cyc; ech[en_n] = int'(o_ch); evl[en_n] = int'(o_value);
            en_n++;
         end
      end
      for (int c = 0; c < NCH; c++)
         check($sformatf("rr grant%0d cycle", c), gcyc[c] - base, 1 + 5 * c);
      check("rr en count", en_n, 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rr en%0d cycle", k), ecyc[k] - base, 6 + 5 * k);
         check($sformatf("rr en%0d ch", k), ech[k], k);
         check($sformatf("rr en%0d value", k), evl[k], k * 10);
      end

      // ---------------- fairness / drop ----------------
      do_reset();
      aim_a[1] = 16'sd10; kp_a[1] = 24'd65536;
      aim_a[2] = 16'sd20; kp_a[2] = 24'd65536;
      gn = 0; drops = 0; odrops = 0; en_n = 0;
      for (int d = 0; d < 30; d++) begin
         i_req = '0;
         if (d <= 11) i_req[1] = 1'b1;
         if (d == 2)  i_req[2] = 1'b1;
         step();
         for (int c = 0; c < NCH; c++)
            if (o_grant[c] && gn < 8) begin
               gseq[gn] = c;
               gn++;
            end
         if (o_drop[1]) drops++;
         if ((o_drop & 4'b1101) != '0) odrops++;
         if (o_en) en_n++;
      end
      i_req = '0;
      check("fair grant count", gn, 4);
      check("fair grant0", gseq[0], 1);
      check("fair grant1", gseq[1], 2);
      check("fair grant2", gseq[2], 1);
      check("fair grant3", gseq[3], 1);
      check("fair drop1 count", drops, 9);
      check("fair other drops", odrops, 0);
      check("fair en count", en_n, 4);

      // ---------------- clear during flight ----------------
      do_reset();
      run_job(2'd1, 16'sd100, 16'sd0, 24'd65536, 24'd0, 16'sd100, "clr ch1a");
      aim_a[0] = 16'sd1000; real_a[0] = '0; kp_a[0] = 24'd32768; ki_a[0] = 24'd2;
      i_req = 4'b0001;
      wait_grant(2'd0, "clr ch0 kill");
      step();
      i_clr = 4'b0001;
      step();
      i_clr = '0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (o_en) seen = 1'b1;
      end
      check("clr killed en", 32'(seen), 0);
      check("clr busy after", 32'(o_busy), 0);
      run_job(2'd0, 16'sd1000, 16'sd0, 24'd32768, 24'd2, 16'sd500, "clr ch0b");
      run_job(2'd1, 16'sd100, 16'sd0, 24'd65536, 24'd0, 16'sd200, "clr ch1b");

      // ---------------- reset mid-job ----------------
      do_reset();
      aim_a[0] = 16'sd1000; kp_a[0] = 24'd32768;
      aim_a[3] = 16'sd1000; kp_a[3] = 24'd32768;
      i_req = 4'b1001;
      wait_grant(2'd0, "rst job");
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst busy", 32'(o_busy), 0);
      check("rst grant", 32'(o_grant), 0);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (o_en || (o_grant != '0) || o_busy) seen = 1'b1;
      end
      check("rst quiet after", 32'(seen), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
